// File: rtl/btn_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_move_ctrl
// Description : Four push-buttons -> synchronize, debounce, press-detect and
//               arbitrate into a single valid/ready move command.
//               Optional auto-repeat is compiled in with macro REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_move_ctrl #(
    parameter int DB_LIMIT      = 1000000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_L,
    input  logic       btn_R,
    input  logic       btn_U,
    input  logic       btn_D,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] move_onehot,
    input  logic       move_ready,
    output logic [7:0] drop_cnt
);

    localparam int                c_db_w   = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
    localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DB_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [3:0] w_btn_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_db;
    logic [3:0] r_db_q;
    logic [3:0] w_press;

    // Bit order L,R,U,D matches the move_dir encoding 0..3
    assign w_btn_raw = {btn_D, btn_U, btn_R, btn_L};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_q  <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= w_db;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic [c_db_w-1:0] r_db_cnt;
        logic              r_db_bit;
        logic              w_edge;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt <= '0;
                r_db_bit <= 1'b0;
            end else if (r_sync2[gi] == r_db_bit) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_max) begin
                r_db_bit <= r_sync2[gi];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end

        assign w_db[gi] = r_db_bit;
        assign w_edge   = r_db_bit & ~r_db_q[gi];

`ifdef REPEAT_EN
        localparam int                 c_rep_w   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        localparam logic [c_rep_w-1:0] c_rep_max = c_rep_w'(REPEAT_CYCLES - 1);

        logic [c_rep_w-1:0] r_rep_cnt;
        logic               r_rep_hit;

        // Counter is 0 in the press-event cycle, so the hit lands exactly
        // REPEAT_CYCLES cycles after each event (initial or repeat).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_cnt <= '0;
                r_rep_hit <= 1'b0;
            end else if (!r_db_bit) begin
                r_rep_cnt <= '0;
                r_rep_hit <= 1'b0;
            end else if (r_rep_cnt == c_rep_max) begin
                r_rep_cnt <= '0;
                r_rep_hit <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
                r_rep_hit <= 1'b0;
            end
        end

        assign w_press[gi] = w_edge | (r_rep_hit & r_db_bit);
`else
        assign w_press[gi] = w_edge;
`endif
    end

`ifndef REPEAT_EN
    // Keeps the repeat period referenced in builds without auto-repeat
    if (REPEAT_CYCLES < 1) begin : g_rep_cfg_unused
    end
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_move_dir;
    logic [1:0] w_dir_nxt;
    logic [3:0] r_move_onehot;
    logic [3:0] w_onehot_nxt;
    logic [7:0] r_drop_cnt;
    logic [1:0] w_pick;
    logic [2:0] w_n_press;
    logic [2:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    assign w_n_press = {2'b00, w_press[0]} + {2'b00, w_press[1]}
                     + {2'b00, w_press[2]} + {2'b00, w_press[3]};

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_move_dir;
        w_onehot_nxt = r_move_onehot;
        w_drop_inc   = w_n_press;
        w_pick       = 2'd3;
        if (w_press[0]) begin
            w_pick = 2'd0;
        end else if (w_press[1]) begin
            w_pick = 2'd1;
        end else if (w_press[2]) begin
            w_pick = 2'd2;
        end
        case (r_state)
            ST_IDLE: begin
                if (|w_press) begin
                    w_state_nxt  = ST_PEND;
                    w_dir_nxt    = w_pick;
                    w_onehot_nxt = 4'b0001 << w_pick;
                    w_drop_inc   = w_n_press - 3'd1;
                end
            end
            ST_PEND: begin
                // Every event here is lost, even in the handshake cycle
                if (move_ready) begin
                    w_state_nxt  = ST_IDLE;
                    w_onehot_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_onehot_nxt = '0;
            end
        endcase
        w_drop_sum = {1'b0, r_drop_cnt} + {6'b000000, w_drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_move_dir    <= '0;
            r_move_onehot <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_move_dir    <= w_dir_nxt;
            r_move_onehot <= w_onehot_nxt;
            r_drop_cnt    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign move_valid  = (r_state == ST_PEND);
    assign move_dir    = r_move_dir;
    assign move_onehot = r_move_onehot;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_btn_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_move_ctrl
// Description : Scoreboard bench for btn_move_ctrl (DB_LIMIT=4, REPEAT_CYCLES=10)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_move_ctrl;

    localparam int DBL = 4;
    localparam int RPC = 10;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       btn_L      = 1'b0;
    logic       btn_R      = 1'b0;
    logic       btn_U      = 1'b0;
    logic       btn_D      = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] move_onehot;
    logic [7:0] drop_cnt;

    btn_move_ctrl #(.DB_LIMIT(DBL), .REPEAT_CYCLES(RPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_L      (btn_L),
        .btn_R      (btn_R),
        .btn_U      (btn_U),
        .btn_D      (btn_D),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_onehot(move_onehot),
        .move_ready (move_ready),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_moves = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_s1[4], m_s2[4], m_db[4], m_dbq[4], m_cnt[4], m_since[4];
    bit         m_pend;
    int         m_drop;
    logic [1:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbq[i] = 0;
            m_cnt[i] = 0; m_since[i] = 0;
        end
        m_pend = 1'b0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [3:0] btn, input logic rdy);
        int evt[4];
        int n;
        int pick;
        n    = 0;
        pick = -1;
        for (int i = 0; i < 4; i++) begin
            evt[i] = (m_db[i] == 1 && m_dbq[i] == 0) ? 1 : 0;
`ifdef REPEAT_EN
            if (m_db[i] == 1 && m_since[i] == RPC) evt[i] = 1;
`endif
            if (evt[i] == 1) begin
                n++;
                if (pick < 0) pick = i;
            end
        end
        if (!m_pend) begin
            if (n > 0) begin
                m_pend = 1'b1;
                exp_q.push_back(2'(pick));
                m_drop += n - 1;
            end
        end else begin
            m_drop += n;
            if (rdy) m_pend = 1'b0;
        end
        if (m_drop > 255) m_drop = 255;
        for (int i = 0; i < 4; i++) begin
            m_dbq[i] = m_db[i];
            if (m_s2[i] == m_db[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] == DBL - 1) begin
                m_db[i]  = m_s2[i];
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
            end
            m_s2[i]    = m_s1[i];
            m_s1[i]    = int'(btn[i]);
            m_since[i] = (evt[i] == 1) ? 1 : m_since[i] + 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge({btn_D, btn_U, btn_R, btn_L}, move_ready);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            chk("valid", int'(move_valid), int'(m_pend));
            chk("drop_cnt", int'(drop_cnt), m_drop);
            if (!move_valid) chk("onehot_idle", int'(move_onehot), 0);
            if (move_valid && move_ready) begin
                n_moves++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_move: got dir %0d, expected no move", move_dir);
                end else begin
                    e = exp_q.pop_front();
                    chk("move_dir", int'(move_dir), int'(e));
                    chk("move_onehot", int'(move_onehot), int'(4'b0001 << e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int hold[4];
        int lvl[4];
        int m0;
        int rst_hold;
        tick(2);
        chk("rst_valid", int'(move_valid), 0);
        chk("rst_dir", int'(move_dir), 0);
        chk("rst_onehot", int'(move_onehot), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        tick(3);

        // Clean press
        btn_U = 1'b1;
        tick(6);
        chk("clean_early", int'(move_valid), 0);
        tick(1);
        chk("clean_valid", int'(move_valid), 1);
        chk("clean_dir", int'(move_dir), 2);
        chk("clean_onehot", int'(move_onehot), 4);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        btn_U = 1'b0;
        chk("clean_clear", int'(move_valid), 0);
        tick(12);
        chk("clean_drop", int'(drop_cnt), 0);

        // Bounce
        for (int k = 0; k < 10; k++) begin
            btn_L = ~btn_L;
            tick(2);
        end
        btn_L = 1'b0;
        tick(12);
        chk("bounce_valid", int'(move_valid), 0);
        chk("bounce_drop", int'(drop_cnt), 0);

        // Simultaneous R + D
        btn_R = 1'b1;
        btn_D = 1'b1;
        tick(8);
        chk("simul_valid", int'(move_valid), 1);
        chk("simul_dir", int'(move_dir), 1);
        chk("simul_drop", int'(drop_cnt), 1);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        btn_R = 1'b0;
        btn_D = 1'b0;
        tick(14);

        // Backpressure
        btn_L = 1'b1;
        tick(8);
        chk("bp_valid", int'(move_valid), 1);
        btn_L = 1'b0;
        tick(2);
        btn_U = 1'b1;
        tick(8);
        chk("bp_dir", int'(move_dir), 0);
        chk("bp_drop", int'(drop_cnt), 2);
        btn_U = 1'b0;
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        tick(14);
        chk("bp_no_u", int'(move_valid), 0);

        // Reset while pending, D held through release
        btn_L = 1'b1;
        tick(8);
        chk("rp_pend", int'(move_valid), 1);
        rst_n = 1'b0;
        btn_L = 1'b0;
        btn_D = 1'b1;
        #1;
        chk("rp_valid_async", int'(move_valid), 0);
        chk("rp_drop_async", int'(drop_cnt), 0);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        chk("rp_early", int'(move_valid), 0);
        tick(1);
        chk("rp_valid", int'(move_valid), 1);
        chk("rp_dir", int'(move_dir), 3);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        btn_D = 1'b0;
        tick(14);

        // Held R with ready high: repeats only when compiled in
        m0 = n_moves;
        move_ready = 1'b1;
        btn_R = 1'b1;
        tick(35);
        btn_R = 1'b0;
        tick(20);
`ifdef REPEAT_EN
        chk("repeat_moves", n_moves - m0, 4);
`else
        chk("repeat_moves", n_moves - m0, 1);
`endif
        move_ready = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 4; i++) begin
            hold[i] = 0;
            lvl[i]  = 0;
        end
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1 - lvl[i];
                    hold[i] = lvl[i] ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 12));
                end
                hold[i]--;
            end
            {btn_D, btn_U, btn_R, btn_L} = {lvl[3][0], lvl[2][0], lvl[1][0], lvl[0][0]};
            move_ready = ($urandom_range(0, 3) != 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n    = 1'b0;
                rst_hold = 2;
            end
            tick(1);
        end
        rst_n = 1'b1;

        // Saturation: no acceptance, many presses
        move_ready = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1 - lvl[i];
                    hold[i] = lvl[i] ? int'($urandom_range(6, 14)) : int'($urandom_range(6, 12));
                end
                hold[i]--;
            end
            {btn_D, btn_U, btn_R, btn_L} = {lvl[3][0], lvl[2][0], lvl[1][0], lvl[0][0]};
            tick(1);
        end
        chk("drop_saturated", int'(drop_cnt), 255);

        // Drain
        {btn_D, btn_U, btn_R, btn_L} = 4'b0000;
        tick(16);
        move_ready = 1'b1;
        tick(4);
        chk("drain_valid", int'(move_valid), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("drop_hold", int'(drop_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
